// File: rtl/if_id_stage_pkg.sv
// if_id_stage_pkg: MIPS-I word width, NOP encoding, instruction field positions and opcodes
package if_id_stage_pkg;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int JADDR_MSB = 25;
  localparam int JADDR_LSB = 0;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
endpackage

// File: rtl/if_id_stage_if.sv
// if_id_stage_if: valid/ready stream carrying an instruction word and its PC+4
interface if_id_stage_if;
  import if_id_stage_pkg::*;
  logic valid;
  logic ready;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] pc4;
  modport master(output valid, instr, pc4, input ready);
  modport slave(input valid, instr, pc4, output ready);
endinterface

// File: rtl/if_id_stage_skid_slot.sv
// if_id_skid_slot: valid + instr + pc4 holding register; invalid contents always read as NOP/0
module if_id_skid_slot
  import if_id_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_i,
  input  logic              clr_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [DATA_W-1:0] pc4_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [DATA_W-1:0] pc4_o
);
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q, instr_d, pc4_q, pc4_d;
  always_comb begin
    valid_d = clr_i ? 1'b0 : ld_i ? valid_i : valid_q;
    instr_d = clr_i ? NOP_WORD : ld_i ? (valid_i ? instr_i : NOP_WORD) : instr_q;
    pc4_d   = clr_i ? '0 : ld_i ? (valid_i ? pc4_i : '0) : pc4_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end
  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: MIPS IF/ID pipeline register with stall/flush; IF_ID_SKID_EN adds a registered-ready skid slot
module if_id_stage
  import if_id_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush_i,
  if_id_stage_if.slave  fetch_i,
  if_id_stage_if.master decode_o,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  shamt_o,
  output logic [5:0]  funct_o,
  output logic [15:0] imm_o,
  output logic [25:0] jaddr_o
);
  logic              main_v, main_free, acc, ld_v;
  logic [DATA_W-1:0] main_instr, main_pc4, ld_instr, ld_pc4;
  assign main_free = !main_v | decode_o.ready;
  assign acc       = fetch_i.valid & fetch_i.ready;
`ifdef IF_ID_SKID_EN
  logic              skid_v;
  logic [DATA_W-1:0] skid_instr, skid_pc4;
  // ready comes straight from the skid flop, breaking the out_ready->in_ready path
  assign fetch_i.ready = !skid_v;
  assign ld_v     = skid_v | acc;
  assign ld_instr = skid_v ? skid_instr : fetch_i.instr;
  assign ld_pc4   = skid_v ? skid_pc4 : fetch_i.pc4;
  if_id_skid_slot u_skid (
    .clk, .rst_n,
    .ld_i(acc & !main_free), .clr_i(flush_i | main_free), .valid_i(1'b1),
    .instr_i(fetch_i.instr), .pc4_i(fetch_i.pc4),
    .valid_o(skid_v), .instr_o(skid_instr), .pc4_o(skid_pc4)
  );
`else
  assign fetch_i.ready = main_free;
  assign ld_v     = acc;
  assign ld_instr = fetch_i.instr;
  assign ld_pc4   = fetch_i.pc4;
`endif
  if_id_skid_slot u_main (
    .clk, .rst_n,
    .ld_i(main_free), .clr_i(flush_i), .valid_i(ld_v),
    .instr_i(ld_instr), .pc4_i(ld_pc4),
    .valid_o(main_v), .instr_o(main_instr), .pc4_o(main_pc4)
  );
  assign decode_o.valid = main_v;
  assign decode_o.instr = main_instr;
  assign decode_o.pc4   = main_pc4;
  assign opcode_o = main_instr[OP_MSB:OP_LSB];
  assign rs_o     = main_instr[RS_MSB:RS_LSB];
  assign rt_o     = main_instr[RT_MSB:RT_LSB];
  assign rd_o     = main_instr[RD_MSB:RD_LSB];
  assign shamt_o  = main_instr[SHAMT_MSB:SHAMT_LSB];
  assign funct_o  = main_instr[FUNCT_MSB:FUNCT_LSB];
  assign imm_o    = main_instr[IMM_MSB:IMM_LSB];
  assign jaddr_o  = main_instr[JADDR_MSB:JADDR_LSB];
endmodule
